// File: rtl/turbo_pkg.sv
// turbo_pkg: shared constants, FSM states and helper functions for the rate-1/3 turbo encoder.
package turbo_pkg;

    localparam int FRAME_LEN = 16;
    localparam int SYMS_PER_FRAME = 3 * FRAME_LEN + 8;
    localparam logic [7:0] DEF_SOFT_MAG = 8'd64;

    typedef enum logic [1:0] {IDLE, DATA, TAIL1, TAIL2} state_t;

    // Bit 0 maps to +mag, bit 1 to -mag (two's complement).
    function automatic logic [7:0] soft_map(input logic b, input logic [7:0] mag);
        return b ? (~mag + 8'd1) : mag;
    endfunction

    function automatic logic [3:0] intlv(input logic [3:0] k, input int a, input int b);
        return 4'(a * int'(k) + b);
    endfunction

endpackage

// File: rtl/turbo_encoder_if.sv
// turbo_encoder_if: frame load and soft-symbol stream handshake of the turbo encoder.
interface turbo_encoder_if;

    logic        i_start;
    logic [15:0] i_data;
    logic        o_busy;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_data;
    logic        o_last;

    modport slave (
        input  i_start, i_data, i_ready,
        output o_busy, o_valid, o_data, o_last
    );

    modport master (
        output i_start, i_data, i_ready,
        input  o_busy, o_valid, o_data, o_last
    );

endinterface

// File: rtl/turbo_rsc.sv
// turbo_rsc: recursive systematic convolutional encoder (g0=7 feedback, g1=5 feedforward) with trellis termination.
module turbo_rsc (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic step,
    input  logic term,
    input  logic u,
    output logic sys,
    output logic par
);

    logic [1:0] s_q, s_d;
    logic       a;

    // s_q[1] is s1, s_q[0] is s2; in termination the input cancels the feedback so a=0.
    always_comb begin
        sys = term ? (s_q[1] ^ s_q[0]) : u;
        a   = sys ^ s_q[1] ^ s_q[0];
        par = a ^ s_q[0];
        s_d = clear ? 2'b00 : step ? {a, s_q[1]} : s_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_q <= 2'b00;
        else        s_q <= s_d;
    end

endmodule

// File: rtl/turbo_encoder.sv
// turbo_encoder: rate-1/3 turbo encoder; loads a 16-bit frame, emits 48 data and 8 tail soft symbols.
module turbo_encoder #(
    parameter int         FRAME_LEN = turbo_pkg::FRAME_LEN,
    parameter int         INTLV_A   = 5,
    parameter int         INTLV_B   = 3,
    parameter logic [7:0] SOFT_MAG  = turbo_pkg::DEF_SOFT_MAG
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    turbo_encoder_if.slave   bus
);

    import turbo_pkg::*;

    if (FRAME_LEN != 16 || 3 * FRAME_LEN + 8 != SYMS_PER_FRAME || INTLV_A % 2 == 0 ||
        INTLV_A < 1 || INTLV_A > 15 || INTLV_B < 0 || INTLV_B > 15) begin : g_bad_param
        $error("turbo_encoder: unsupported FRAME_LEN/INTLV_A/INTLV_B");
    end

    state_t      state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [1:0]  ph_q, ph_d;
    logic [15:0] frame_q, frame_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        xfer, last_sym, clear, step1, step2, sym_bit;
    logic        sys1, par1, sys2, par2;

    turbo_rsc u_rsc1 (
        .clk(i_clk), .rst_n(i_rst_n), .clear(clear), .step(step1),
        .term(state_q == TAIL1), .u(frame_q[k_q]), .sys(sys1), .par(par1)
    );

    turbo_rsc u_rsc2 (
        .clk(i_clk), .rst_n(i_rst_n), .clear(clear), .step(step2),
        .term(state_q == TAIL2), .u(frame_q[intlv(k_q, INTLV_A, INTLV_B)]), .sys(sys2), .par(par2)
    );

    // The output symbol is decoded from the held pointer and RSC states, so it is stable under backpressure.
    always_comb begin
        xfer     = valid_q && bus.i_ready;
        last_sym = state_q == TAIL2 && k_q == 4'd1 && ph_q == 2'd1;
        step1    = xfer && ((state_q == DATA && ph_q == 2'd2) || (state_q == TAIL1 && ph_q == 2'd1));
        step2    = xfer && ((state_q == DATA && ph_q == 2'd2) || (state_q == TAIL2 && ph_q == 2'd1));
        sym_bit  = state_q == DATA  ? (ph_q == 2'd0 ? frame_q[k_q] : ph_q == 2'd1 ? par1 : par2) :
                   state_q == TAIL1 ? (ph_q == 2'd0 ? sys1 : par1) :
                                      (ph_q == 2'd0 ? sys2 : par2);
        state_d  = state_q;
        k_d      = k_q;
        ph_d     = ph_q;
        frame_d  = frame_q;
        clear    = 1'b0;
        busy_d   = state_q != IDLE && !(xfer && last_sym);
        valid_d  = state_q != IDLE && !(xfer && last_sym);
        case (state_q)
            IDLE: if (bus.i_start) begin
                state_d = DATA;
                frame_d = bus.i_data;
                k_d     = 4'd0;
                ph_d    = 2'd0;
                busy_d  = 1'b1;
                clear   = 1'b1;
            end
            DATA: if (xfer) begin
                ph_d    = ph_q == 2'd2 ? 2'd0 : ph_q + 2'd1;
                k_d     = ph_q == 2'd2 ? k_q + 4'd1 : k_q;
                state_d = ph_q == 2'd2 && k_q == 4'd15 ? TAIL1 : DATA;
            end
            TAIL1: if (xfer) begin
                ph_d    = ph_q == 2'd1 ? 2'd0 : 2'd1;
                k_d     = ph_q == 2'd1 ? (k_q == 4'd1 ? 4'd0 : k_q + 4'd1) : k_q;
                state_d = ph_q == 2'd1 && k_q == 4'd1 ? TAIL2 : TAIL1;
            end
            TAIL2: if (xfer) begin
                ph_d    = ph_q == 2'd1 ? 2'd0 : 2'd1;
                k_d     = ph_q == 2'd1 ? k_q + 4'd1 : k_q;
                state_d = last_sym ? IDLE : TAIL2;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            k_q     <= 4'd0;
            ph_q    <= 2'd0;
            frame_q <= 16'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ph_q    <= ph_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.o_busy  = busy_q;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = valid_q ? soft_map(sym_bit, SOFT_MAG) : 8'd0;
    assign bus.o_last  = valid_q && last_sym;

endmodule
